imm_decode_stage: RTL

Registered, parametrised immediate-decode stage between instruction fetch and register read. It accepts one 32-bit instruction plus PC per cycle over a valid/ready handshake and decodes the sign/zero-extended XLEN-wide immediate and its format class. Illegal opcodes are flagged. Results are held in a 2-entry elastic buffer so that fetch and decode stall independently. Unlike the existing combinational immediate extender, it adds XLEN generalisation (RV32/RV64), correct I-type JALR, LUI, CSR zimm and shift-amount handling, illegal detection, pipelining, back-pressure and flush.

---
 rtl/imm_decode_stage.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: decodes the RISC-V immediate, format class and legality of a
// fetched instruction and queues the result in a 2-entry elastic buffer.
module imm_decode_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

   typedef enum logic [2:0] {
      FMT_R  = 3'd0,
      FMT_I  = 3'd1,
      FMT_S  = 3'd2,
      FMT_B  = 3'd3,
      FMT_U  = 3'd4,
      FMT_J  = 3'd5,
      FMT_Z  = 3'd6,
      FMT_SH = 3'd7
   } fmt_e;

   generate
      if (XLEN != 32 && XLEN != 64) begin : gen_bad_xlen
         $error("imm_decode_stage: XLEN must be 32 or 64");
      end
   endgenerate

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [XLEN-1:0] immI, immS, immB, immU, immJ;
   logic            shamt5Ok, shamt6Ok;
   logic [XLEN-1:0] rawImm, decImm;
   fmt_e            rawFmt, decFmt;
   logic            rawIllegal;

   assign opcode   = in_instr[6:0];
   assign funct3   = in_instr[14:12];
   assign immI     = XLEN'($signed(in_instr[31:20]));
   assign immS     = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
   assign immB     = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
   assign immU     = XLEN'($signed({in_instr[31:12], 12'b0}));
   assign immJ     = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
   // Only SRAI/SRAIW may carry the arithmetic bit; SLLI must have a clean upper field.
   assign shamt5Ok = (in_instr[31:25] == 7'b0000000) ||
                     (in_instr[31:25] == 7'b0100000 && funct3 == 3'b101);
   assign shamt6Ok = (in_instr[31:26] == 6'b000000) ||
                     (in_instr[31:26] == 6'b010000 && funct3 == 3'b101);

   always_comb begin
      rawImm     = '0;
      rawFmt     = FMT_R;
      rawIllegal = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC: begin
            rawFmt = FMT_U;
            rawImm = immU;
         end
         OPC_JAL: begin
            rawFmt = FMT_J;
            rawImm = immJ;
         end
         OPC_JALR: begin
            rawFmt     = FMT_I;
            rawImm     = immI;
            rawIllegal = (funct3 != 3'b000);
         end
         OPC_BRANCH: begin
            rawFmt     = FMT_B;
            rawImm     = immB;
            rawIllegal = (funct3[2:1] == 2'b01);
         end
         OPC_LOAD, OPC_MISC_MEM: begin
            rawFmt = FMT_I;
            rawImm = immI;
         end
         OPC_STORE: begin
            rawFmt = FMT_S;
            rawImm = immS;
         end
         OPC_OP_IMM: begin
            if (funct3[1:0] == 2'b01) begin
               rawFmt = FMT_SH;
               if (XLEN == 64) begin
                  rawImm     = XLEN'(in_instr[25:20]);
                  rawIllegal = !shamt6Ok;
               end else begin
                  rawImm     = XLEN'(in_instr[24:20]);
                  rawIllegal = !shamt5Ok;
               end
            end else begin
               rawFmt = FMT_I;
               rawImm = immI;
            end
         end
         OPC_OP_IMM_32: begin
            if (XLEN != 64) begin
               rawIllegal = 1'b1;
            end else if (funct3[1:0] == 2'b01) begin
               rawFmt     = FMT_SH;
               rawImm     = XLEN'(in_instr[24:20]);
               rawIllegal = !shamt5Ok;
            end else begin
               rawFmt = FMT_I;
               rawImm = immI;
            end
         end
         OPC_OP: begin
            rawFmt = FMT_R;
         end
         OPC_OP_32: begin
            rawIllegal = (XLEN != 64);
         end
         OPC_SYSTEM: begin
            if (funct3[2]) begin
               rawFmt = FMT_Z;
               rawImm = XLEN'(in_instr[19:15]);
            end else begin
               rawFmt = FMT_I;
               rawImm = immI;
            end
         end
         default: begin
            rawIllegal = 1'b1;
         end
      endcase
   end

   // Illegal instructions are still forwarded, but with a neutral payload.
   assign decFmt = rawIllegal ? FMT_R : rawFmt;
   assign decImm = rawIllegal ? '0 : rawImm;

   logic [31:0]     instrQ   [2];
   logic [XLEN-1:0] pcQ      [2];
   logic [XLEN-1:0] immQ     [2];
   logic [2:0]      fmtQ     [2];
   logic            illegalQ [2];
   logic            rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
   logic [1:0]      count_q, count_d;
   logic            push, pop;

   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      rdPtr_d = rdPtr_q;
      wrPtr_d = wrPtr_q;
      count_d = count_q;
      if (flush) begin
         rdPtr_d = 1'b0;
         wrPtr_d = 1'b0;
         count_d = 2'd0;
      end else begin
         if (push) wrPtr_d = ~wrPtr_q;
         if (pop)  rdPtr_d = ~rdPtr_q;
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdPtr_q <= 1'b0;
         wrPtr_q <= 1'b0;
         count_q <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            instrQ[i]   <= '0;
            pcQ[i]      <= '0;
            immQ[i]     <= '0;
            fmtQ[i]     <= '0;
            illegalQ[i] <= 1'b0;
         end
      end else begin
         rdPtr_q <= rdPtr_d;
         wrPtr_q <= wrPtr_d;
         count_q <= count_d;
         if (push && !flush) begin
            instrQ[wrPtr_q]   <= in_instr;
            pcQ[wrPtr_q]      <= in_pc;
            immQ[wrPtr_q]     <= decImm;
            fmtQ[wrPtr_q]     <= decFmt;
            illegalQ[wrPtr_q] <= rawIllegal;
         end
      end
   end

   assign out_instr   = instrQ[rdPtr_q];
   assign out_pc      = pcQ[rdPtr_q];
   assign out_imm     = immQ[rdPtr_q];
   assign out_fmt     = fmtQ[rdPtr_q];
   assign out_illegal = illegalQ[rdPtr_q];

endmodule
